// File: rtl/ps2_key_sequencer.sv
// PS/2 receive sequencer: syncs raw lines, frames and checks bytes, folds E0/F0 prefixes into key events.
// Latency: events/pulses one cycle after the stop-bit edge; a full, unaccepted event register drops new events with overrun.
module ps2_key_sequencer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       event_ready,
  output logic       event_valid,
  output logic [7:0] event_code,
  output logic       event_release,
  output logic       event_extended,
  output logic       kbd_reset_seen,
  output logic       frame_error,
  output logic       overrun
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             ext_pend_q, ext_pend_d, rel_pend_q, rel_pend_d;
  logic             evt_valid_q, evt_valid_d;
  logic [7:0]       evt_code_q, evt_code_d;
  logic             evt_rel_q, evt_rel_d, evt_ext_q, evt_ext_d;
  logic             bat_q, bat_d, ferr_q, ferr_d, ovr_q, ovr_d;

  logic             fall;
  logic             tmo_hit;
  logic             byte_ok;
  logic             new_evt;

  assign fall    = clk_prev_q & ~clk_s2_q;
  assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    clk_s1_d    = ps2_clk;
    clk_s2_d    = clk_s1_q;
    clk_prev_d  = clk_s2_q;
    dat_s1_d    = ps2_data;
    dat_s2_d    = dat_s1_q;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    tmo_cnt_d   = tmo_cnt_q;
    ext_pend_d  = ext_pend_q;
    rel_pend_d  = rel_pend_q;
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_rel_d   = evt_rel_q;
    evt_ext_d   = evt_ext_q;
    bat_d       = 1'b0;
    ferr_d      = 1'b0;
    ovr_d       = 1'b0;
    byte_ok     = 1'b0;
    new_evt     = 1'b0;

    // A stalled frame is abandoned before any edge arriving in the same cycle is considered.
    if (tmo_hit) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      tmo_cnt_d = '0;
      ferr_d    = 1'b1;
    end else begin
      if (fall) begin
        tmo_cnt_d = '0;
      end else if (state_q != IDLE) begin
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
      end

      if (fall) begin
        case (state_q)
          IDLE: begin
            if (!dat_s2_q) begin
              state_d   = DATA;
              bit_cnt_d = 3'd0;
            end
          end
          DATA: begin
            shift_d   = {dat_s2_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = PARITY;
            end
          end
          PARITY: begin
            parity_d = dat_s2_q;
            state_d  = STOP;
          end
          STOP: begin
            state_d = IDLE;
            if (dat_s2_q && ((^shift_q) ^ parity_q)) begin
              byte_ok = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    if (byte_ok) begin
      case (shift_q)
        8'hE0: ext_pend_d = 1'b1;
        8'hF0: rel_pend_d = 1'b1;
        8'hAA: begin
          bat_d      = 1'b1;
          ext_pend_d = 1'b0;
          rel_pend_d = 1'b0;
        end
        default: begin
          new_evt    = 1'b1;
          ext_pend_d = 1'b0;
          rel_pend_d = 1'b0;
        end
      endcase
    end

    if (evt_valid_q && event_ready) begin
      evt_valid_d = 1'b0;
    end

    // The register is reusable in the very cycle its current event is accepted.
    if (new_evt) begin
      if (!evt_valid_q || event_ready) begin
        evt_valid_d = 1'b1;
        evt_code_d  = shift_q;
        evt_rel_d   = rel_pend_q;
        evt_ext_d   = ext_pend_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      clk_prev_q  <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      parity_q    <= 1'b0;
      tmo_cnt_q   <= '0;
      ext_pend_q  <= 1'b0;
      rel_pend_q  <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 8'h00;
      evt_rel_q   <= 1'b0;
      evt_ext_q   <= 1'b0;
      bat_q       <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      clk_prev_q  <= clk_prev_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_cnt_q   <= tmo_cnt_d;
      ext_pend_q  <= ext_pend_d;
      rel_pend_q  <= rel_pend_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_rel_q   <= evt_rel_d;
      evt_ext_q   <= evt_ext_d;
      bat_q       <= bat_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign event_valid    = evt_valid_q;
  assign event_code     = evt_code_q;
  assign event_release  = evt_rel_q;
  assign event_extended = evt_ext_q;
  assign kbd_reset_seen = bat_q;
  assign frame_error    = ferr_q;
  assign overrun        = ovr_q;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: table of frames with expected events plus hand-timed corner sequences.
module tb_ps2_key_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic       event_ready;
  logic       event_valid;
  logic [7:0] event_code;
  logic       event_release;
  logic       event_extended;
  logic       kbd_reset_seen;
  logic       frame_error;
  logic       overrun;

  ps2_key_sequencer #(.TIMEOUT_CYCLES(50)) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2_clk       (ps2_clk),
    .ps2_data      (ps2_data),
    .event_ready   (event_ready),
    .event_valid   (event_valid),
    .event_code    (event_code),
    .event_release (event_release),
    .event_extended(event_extended),
    .kbd_reset_seen(kbd_reset_seen),
    .frame_error   (frame_error),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       bad_stop;
    int         exp_evt;
    logic [7:0] exp_code;
    logic       exp_rel;
    logic       exp_ext;
    int         exp_ferr;
    int         exp_bat;
  } vec_t;

  vec_t tv [18];

  int n_checks = 0;
  int n_pass   = 0;

  // Observed activity, sampled on the falling clk edge.
  int         evt_cnt = 0, ferr_cnt = 0, bat_cnt = 0, ovr_cnt = 0, long_cnt = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_rel = 1'b0, last_ext = 1'b0;
  logic       ferr_prev = 1'b0, bat_prev = 1'b0, ovr_prev = 1'b0;

  always @(negedge clk) begin
    if (event_valid && event_ready) begin
      evt_cnt++;
      last_code = event_code;
      last_rel  = event_release;
      last_ext  = event_extended;
    end
    if (frame_error) ferr_cnt++;
    if (kbd_reset_seen) bat_cnt++;
    if (overrun) ovr_cnt++;
    if ((frame_error && ferr_prev) || (kbd_reset_seen && bat_prev) || (overrun && ovr_prev)) long_cnt++;
    ferr_prev = frame_error;
    bat_prev  = kbd_reset_seen;
    ovr_prev  = overrun;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cyc(10);
    ps2_clk = 1'b0;
    cyc(10);
    ps2_clk = 1'b1;
  endtask

  task automatic send_head(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_head(b, bad_par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    cyc(5);
  endtask

  // Stop bit driven by hand: leaves the bench 2 cycles after the line falls (the edge-detect cycle).
  task automatic stop_fall_head;
    ps2_data = 1'b1;
    cyc(10);
    ps2_clk = 1'b0;
    cyc(2);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, event_valid, 0);
    check({tag, "_code"}, event_code, 0);
    check({tag, "_rel"}, event_release, 0);
    check({tag, "_ext"}, event_extended, 0);
    check({tag, "_bat"}, kbd_reset_seen, 0);
    check({tag, "_ferr"}, frame_error, 0);
    check({tag, "_ovr"}, overrun, 0);
  endtask

  initial begin
    int e0, f0, b0, o0;

    tv[0]  = '{8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 1'b0, 0, 0};
    tv[1]  = '{8'hE0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 0};
    tv[2]  = '{8'hF0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 0};
    tv[3]  = '{8'h75, 1'b0, 1'b0, 1, 8'h75, 1'b1, 1'b1, 0, 0};
    tv[4]  = '{8'h75, 1'b0, 1'b0, 1, 8'h75, 1'b0, 1'b0, 0, 0};
    tv[5]  = '{8'h1C, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1, 0};
    tv[6]  = '{8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 1'b0, 0, 0};
    tv[7]  = '{8'hF0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 0};
    tv[8]  = '{8'hAA, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 1};
    tv[9]  = '{8'h1C, 1'b0, 1'b0, 1, 8'h1C, 1'b0, 1'b0, 0, 0};
    tv[10] = '{8'hF0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 0};
    tv[11] = '{8'hE0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 0};
    tv[12] = '{8'h6B, 1'b0, 1'b0, 1, 8'h6B, 1'b1, 1'b1, 0, 0};
    tv[13] = '{8'hE0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 0};
    tv[14] = '{8'hF0, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1, 0};
    tv[15] = '{8'h74, 1'b0, 1'b0, 1, 8'h74, 1'b0, 1'b1, 0, 0};
    tv[16] = '{8'h1C, 1'b0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 1, 0};
    tv[17] = '{8'h5A, 1'b0, 1'b0, 1, 8'h5A, 1'b0, 1'b0, 0, 0};

    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    event_ready = 1'b0;
    cyc(3);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(5);

    // Plain key: edge-to-valid latency, hold while not ready, drop after a 1-cycle accept.
    send_head(8'h1C, 1'b0);
    stop_fall_head();
    @(negedge clk);
    check("lat_early_valid", event_valid, 0);
    @(posedge clk); @(negedge clk);
    check("lat_valid", event_valid, 1);
    check("plain_code", event_code, 8'h1C);
    check("plain_rel", event_release, 0);
    check("plain_ext", event_extended, 0);
    cyc(3);
    check("plain_hold", event_valid, 1);
    event_ready = 1'b1;
    cyc(1);
    event_ready = 1'b0;
    @(negedge clk);
    check("plain_drop", event_valid, 0);
    cyc(6);
    ps2_clk = 1'b1;
    cyc(5);

    event_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      e0 = evt_cnt; f0 = ferr_cnt; b0 = bat_cnt; o0 = ovr_cnt;
      send_frame(tv[i].b, tv[i].bad_par, tv[i].bad_stop);
      check($sformatf("vec%0d_evts", i), evt_cnt - e0, tv[i].exp_evt);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, tv[i].exp_ferr);
      check($sformatf("vec%0d_bat", i), bat_cnt - b0, tv[i].exp_bat);
      check($sformatf("vec%0d_ovr", i), ovr_cnt - o0, 0);
      if (tv[i].exp_evt != 0) begin
        check($sformatf("vec%0d_code", i), last_code, tv[i].exp_code);
        check($sformatf("vec%0d_rel", i), last_rel, tv[i].exp_rel);
        check($sformatf("vec%0d_ext", i), last_ext, tv[i].exp_ext);
      end
    end

    // Overrun: second event dropped while the first is held.
    event_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b0);
    check("ovr_valid", event_valid, 1);
    check("ovr_code_kept", event_code, 8'h1C);
    check("ovr_pulses", ovr_cnt - o0, 1);
    event_ready = 1'b1;
    cyc(1);
    event_ready = 1'b0;
    cyc(2);
    check("ovr_drained", event_valid, 0);

    // Accept in the exact cycle the next event completes: load, no overrun.
    send_frame(8'h1C, 1'b0, 1'b0);
    o0 = ovr_cnt; e0 = evt_cnt;
    send_head(8'h32, 1'b0);
    stop_fall_head();
    event_ready = 1'b1;
    cyc(1);
    event_ready = 1'b0;
    @(negedge clk);
    check("same_cyc_valid", event_valid, 1);
    check("same_cyc_code", event_code, 8'h32);
    check("same_cyc_ovr", ovr_cnt - o0, 0);
    check("same_cyc_accepts", evt_cnt - e0, 1);
    cyc(6);
    ps2_clk = 1'b1;
    cyc(5);
    event_ready = 1'b1;
    cyc(2);

    // Timeout: clock stops after 4 data bits.
    f0 = ferr_cnt; e0 = evt_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    cyc(80);
    check("tmo_ferr", ferr_cnt - f0, 1);
    check("tmo_no_evt", evt_cnt - e0, 0);
    send_frame(8'h29, 1'b0, 1'b0);
    check("tmo_next_evts", evt_cnt - e0, 1);
    check("tmo_next_code", last_code, 8'h29);
    check("tmo_next_rel", last_rel, 0);
    check("tmo_next_ext", last_ext, 0);
    check("tmo_next_ferr", ferr_cnt - f0, 1);

    // Reset mid-frame with a held event and a pending E0.
    event_ready = 1'b0;
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    f0 = ferr_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    rst = 1'b1;
    cyc(2);
    @(negedge clk);
    check_outputs_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(3);
    event_ready = 1'b1;
    e0 = evt_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    check("midrst_evts", evt_cnt - e0, 1);
    check("midrst_code", last_code, 8'h1C);
    check("midrst_ext", last_ext, 0);
    check("midrst_rel", last_rel, 0);
    check("midrst_no_ferr", ferr_cnt - f0, 0);

    check("pulse_width", long_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
